aes_key_schedule_iter: RTL and testbench
========================================

Name: aes_key_schedule_iter

Overview:
- Iterative AES-128 key-expansion stage that sits directly downstream of the S-box.
- Takes a 128-bit cipher key and produces round keys 0..10, one per accepted beat, over a valid/ready stream.
- Stores all 11 round keys in an internal table with random-access readback for the cipher and inverse-cipher datapaths.
- Each round is computed with SubWord: four S-box instances on RotWord(w3).

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.
- KW, 128, key and round-key width. Fixed at 128.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin expansion of key_in; sampled only in IDLE
- key_in  in  128  cipher key; byte 0 = bits [127:120]
- busy  out  1  high in GEN state
- rk_valid  out  1  rk_data/rk_idx hold a valid round key
- rk_ready  in  1  downstream accepts the current round key
- rk_idx  out  4  round index of rk_data, 0..10
- rk_data  out  128  current round key
- done  out  1  one-cycle pulse after round key 10 is accepted
- rd_idx  in  4  table read index
- rd_data  out  128  table entry rd_idx, combinational read; 0 if rd_idx > 10
- table_valid  out  1  all 11 table entries are valid for the most recent key

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, rk_valid, done, table_valid = 0; rk_idx=0; rk_data=0; all table entries=0.
- States: IDLE, GEN.
- IDLE with start=1:
  - next cycle: state=GEN, rk_data=key_in, rk_idx=0, rk_valid=1, busy=1.
  - table[0] is written with key_in; table_valid clears.
  - key_in is sampled only on this edge.
- IDLE with start=0: hold all outputs; done=0.
- GEN, handshake (rk_valid & rk_ready) with rk_idx<10:
  - next cycle: rk_data=next_key(rk_data, rcon[rk_idx]), rk_idx+1, stays in GEN.
  - the new key is written to table[rk_idx+1] on the same edge.
- GEN, handshake with rk_idx=10: next cycle state=IDLE, rk_valid=0, busy=0, done=1 (one cycle only), table_valid=1.
- GEN without handshake: rk_data and rk_idx stable; valid is never withdrawn. This is a full stall of arbitrary length.
- start while in GEN is ignored. key_in may change freely during GEN.
- A start in the same cycle that done is high is accepted, because the state is already IDLE.
- Throughput with rk_ready held high:
  - key k is presented in cycle start+1+k.
  - done is high at start+12.
- next_key computation, with words w0=[127:96], w1, w2, w3=[31:0]:
  - t = SubWord({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
  - next_key is combinational: one round per clock, no pipelining.
- rcon sequence for rk_idx 0..9: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- Reset during GEN aborts immediately to the reset values. The table is cleared and no done pulse is produced.
- rd_data is a pure combinational mux of the table. It is readable at all times; entries above the current progress hold the previous key's values or 0 after reset.

Decomposition:
- Shared package aes_pkg holds:
  - localparams AES_NR=10, AES_KW=128;
  - an RCON[0:9] constant array;
  - a state enum {IDLE, GEN}.
- Sub-module sub_word (32-bit in/out) instantiates four existing S-box modules, one per byte, with no added logic.
- next_key stays inline in this block.

Test Plan:
- FIPS-197 A.1 vector, key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1:
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done at cycle start+12; table_valid=1 afterwards.
- All-zero key:
  - idx1 = 62636363626363636263636362636363
  - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e
  - rd_idx=10 returns the same value after done; rd_idx=11..15 returns 0.
- Backpressure, A.1 key with rk_ready low for 5 cycles at idx 3:
  - rk_valid stays 1 and rk_idx stays 3 with data frozen;
  - the resulting sequence is identical to the unstalled run;
  - done is delayed by exactly 5 cycles.
- start reasserted with a different key at idx 4:
  - ignored; output and table sequence match the original key;
  - a back-to-back start in the done cycle begins a new expansion on the next cycle.
- rst asserted asynchronously at idx 6:
  - outputs drop to reset values before the next clock edge;
  - no done pulse; table_valid=0 and all table entries read 0;
  - a subsequent start expands correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, the key-schedule state type and GF(2^8) helpers
// used by the S-box and the key-expansion stage.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_KW = 128;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] inv;

    always_comb begin
        inv  = gf_inv(din);
        dout = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

endmodule

// File: rtl/sub_word.sv
// SubWord: one S-box per byte of a 32-bit word.
module sub_word (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .din  (din[gi*8 +: 8]),
                .dout (dout[gi*8 +: 8])
            );
        end
    endgenerate

endmodule

// File: rtl/aes_key_schedule_iter.sv
// Iterative AES-128 key expansion: one round key per accepted beat, with all
// eleven round keys retained in a readable table.
module aes_key_schedule_iter
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic          busy,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [3:0]    rk_idx,
    output logic [KW-1:0] rk_data,
    output logic          done,
    input  logic [3:0]    rd_idx,
    output logic [KW-1:0] rd_data,
    output logic          table_valid
);

    if (NR != AES_NR || KW != AES_KW) begin : g_param_check
        $error("aes_key_schedule_iter supports only AES-128 (NR=10, KW=128)");
    end

    state_t        state_reg;
    logic [3:0]    idx_reg;
    logic [127:0]  data_reg;
    logic          done_reg;
    logic          table_valid_reg;
    logic [127:0]  table_q [0:10];

    logic          load;
    logic          fire;
    logic          last;
    logic [7:0]    rcon;
    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   sub_out;
    logic [31:0]   t;
    logic [31:0]   n0, n1, n2, n3;
    logic [127:0]  next_key;

    // In GEN the current key is always valid, so a handshake is just rk_ready.
    assign load = (state_reg == IDLE) && start;
    assign fire = (state_reg == GEN) && rk_ready;
    assign last = (idx_reg == 4'(NR));

    assign rcon = (idx_reg < 4'(NR)) ? RCON[idx_reg] : 8'h00;

    assign w0 = data_reg[127:96];
    assign w1 = data_reg[95:64];
    assign w2 = data_reg[63:32];
    assign w3 = data_reg[31:0];

    sub_word u_sub_word (
        .din  ({w3[23:0], w3[31:24]}),
        .dout (sub_out)
    );

    assign t  = sub_out ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= 4'd0;
            data_reg        <= '0;
            done_reg        <= 1'b0;
            table_valid_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg       <= GEN;
                        idx_reg         <= 4'd0;
                        data_reg        <= key_in;
                        table_valid_reg <= 1'b0;
                    end
                end
                GEN: begin
                    if (rk_ready) begin
                        if (last) begin
                            state_reg       <= IDLE;
                            done_reg        <= 1'b1;
                            table_valid_reg <= 1'b1;
                        end else begin
                            idx_reg  <= idx_reg + 4'd1;
                            data_reg <= next_key;
                        end
                    end
                end
            endcase
        end
    end

    // Entry 0 takes the cipher key on load; entry k takes the key derived from
    // entry k-1 on the handshake that advances rk_idx to k.
    genvar gi;
    generate
        for (gi = 0; gi <= 10; gi++) begin : g_table
            logic [127:0] entry_reg;
            logic         wr_en;
            logic [127:0] wr_data;

            if (gi == 0) begin : g_first
                assign wr_en   = load;
                assign wr_data = key_in;
            end else begin : g_rest
                assign wr_en   = fire && !last && (idx_reg == 4'(gi - 1));
                assign wr_data = next_key;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (wr_en) begin
                    entry_reg <= wr_data;
                end
            end

            assign table_q[gi] = entry_reg;
        end
    endgenerate

    assign rd_data     = (rd_idx <= 4'(NR)) ? table_q[rd_idx] : '0;
    assign busy        = (state_reg == GEN);
    assign rk_valid    = (state_reg == GEN);
    assign rk_idx      = idx_reg;
    assign rk_data     = data_reg;
    assign done        = done_reg;
    assign table_valid = table_valid_reg;

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// Bench for aes_key_schedule_iter: FIPS-197 vectors, scoreboarded round-key
// stream, backpressure, ignored start, back-to-back start and async reset.
module tb_aes_key_schedule_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         done;
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;
    logic         table_valid;

    always #5 clk = ~clk;

    aes_key_schedule_iter #(.NR(10), .KW(128)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key_in      (key_in),
        .busy        (busy),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_idx      (rk_idx),
        .rk_data     (rk_data),
        .done        (done),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .table_valid (table_valid)
    );

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
    } rk_t;

    vec_t         vecs [0:5];
    rk_t          sb_q [$];
    rk_t          sb_e;
    logic [7:0]   sbox_t [0:255];
    logic [127:0] exp_keys [0:10];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           done_cnt = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] rl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box built by walking generator 3 and its inverse together.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [127:0] k);
        logic [7:0]  rc;
        logic [31:0] a, b, c, d, t;
        rc = 8'h01;
        exp_keys[0] = k;
        for (int r = 1; r <= 10; r++) begin
            {a, b, c, d} = exp_keys[r-1];
            t = sw({d[23:0], d[31:24]}) ^ {rc, 24'h0};
            a = a ^ t;
            b = b ^ a;
            c = c ^ b;
            d = d ^ c;
            exp_keys[r] = {a, b, c, d};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
    endtask

    // Caller is positioned just after a rising edge; start is seen on the next one.
    task automatic start_key(input logic [127:0] k);
        start     = 1'b1;
        key_in    = k;
        start_cyc = cyc;
        model_expand(k);
        for (int i = 0; i <= 10; i++) sb_q.push_back('{4'(i), exp_keys[i]});
        @(posedge clk); #2;
        start  = 1'b0;
        key_in = ~k;
    endtask

    task automatic wait_done(input int delta);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #2;
            if (done) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL done_timeout actual=none required=done");
        end else begin
            check("done_cycle", 128'(cyc - start_cyc), 128'(delta));
            check("done_tv", 128'(table_valid), 128'd1);
            check("done_busy", 128'(busy), 128'd0);
        end
    endtask

    task automatic wait_idx(input logic [3:0] target);
        for (int i = 0; i < 30 && rk_idx != target; i++) begin
            @(posedge clk); #2;
        end
        check("wait_idx", 128'(rk_idx), 128'(target));
    endtask

    task automatic readback(input string name);
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            #1;
            check(name, rd_data, exp_keys[i]);
        end
        @(posedge clk); #2;
    endtask

    // Scoreboard: every accepted round key is popped and compared here.
    initial forever begin
        @(negedge clk);
        if (!rst && rk_valid && rk_ready) begin
            $display("rk idx=%0d data=%h", rk_idx, rk_data);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=idx%0d required=none", rk_idx);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_idx", 128'(rk_idx), 128'(sb_e.idx));
                check("sb_data", rk_data, sb_e.data);
            end
        end
        if (!rst && done) done_cnt++;
    end

    initial begin
        logic [127:0] last_key;
        bit           have_key;
        int           dc;

        vecs[0] = '{KEY_A1,   4'd0,  KEY_A1};
        vecs[1] = '{KEY_A1,   4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{KEY_A1,   4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{KEY_ZERO, 4'd0,  KEY_ZERO};
        vecs[4] = '{KEY_ZERO, 4'd1,  128'h62636363626363636263636362636363};
        vecs[5] = '{KEY_ZERO, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        build_sbox();
        rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b1; rd_idx = 4'd0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_tv", 128'(table_valid), 128'd0);
        check("rst_idx", 128'(rk_idx), 128'd0);
        check("rst_data", rk_data, 128'd0);
        rd_idx = 4'd10;
        #1;
        check("rst_rd10", rd_data, 128'd0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Table-driven FIPS-197 vectors through the stream and the readback port.
        have_key = 1'b0;
        last_key = '0;
        for (int v = 0; v < 6; v++) begin
            if (!have_key || vecs[v].key !== last_key) begin
                start_key(vecs[v].key);
                wait_done(12);
                @(posedge clk); #2;
                check("done_pulse_end", 128'(done), 128'd0);
                have_key = 1'b1;
                last_key = vecs[v].key;
            end
            rd_idx = vecs[v].idx;
            #1;
            check("vec_rd", rd_data, vecs[v].exp);
        end
        @(posedge clk); #2;
        readback("zero_table");
        for (int i = 11; i <= 15; i++) begin
            rd_idx = 4'(i);
            #1;
            check("rd_oob", rd_data, 128'd0);
        end
        @(posedge clk); #2;

        // Five-cycle stall at idx 3, then a back-to-back start in the done cycle.
        start_key(KEY_A1);
        wait_idx(4'd3);
        rk_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 128'(rk_valid), 128'd1);
            check("stall_idx", 128'(rk_idx), 128'd3);
            check("stall_data", rk_data, exp_keys[3]);
            @(posedge clk); #2;
        end
        rk_ready = 1'b1;
        wait_done(17);
        start_key(KEY_ZERO);
        check("b2b_busy", 128'(busy), 128'd1);
        check("b2b_idx", 128'(rk_idx), 128'd0);
        check("b2b_data", rk_data, KEY_ZERO);
        wait_done(12);
        readback("b2b_table");

        // A start with a different key mid-expansion is ignored.
        start_key(KEY_A1);
        wait_idx(4'd4);
        start  = 1'b1;
        key_in = 128'hdeadbeef_00112233_44556677_8899aabb;
        @(posedge clk); #2;
        start = 1'b0;
        check("ign_busy", 128'(busy), 128'd1);
        wait_done(12);
        readback("ign_table");

        // Asynchronous reset mid-expansion.
        start_key(KEY_A1);
        wait_idx(4'd6);
        #1;
        rst = 1'b1;
        sb_q.delete();
        dc = done_cnt;
        #1;
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_valid", 128'(rk_valid), 128'd0);
        check("arst_idx", 128'(rk_idx), 128'd0);
        check("arst_data", rk_data, 128'd0);
        check("arst_tv", 128'(table_valid), 128'd0);
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            #1;
            check("arst_table", rd_data, 128'd0);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("arst_no_done", 128'(done_cnt), 128'(dc));
        start_key(KEY_ZERO);
        wait_done(12);
        readback("post_rst_table");

        check("sb_empty", 128'(sb_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
